// File: rtl/bopit_round_ctrl.sv
// Round controller for the reaction game: turns the random stream into one-hot
// prompts, times the player's response and keeps the score.
module bopit_round_ctrl #(
  parameter int RAND_W      = 5,
  parameter int START_LIMIT = 2000,
  parameter int LIMIT_STEP  = 100,
  parameter int MIN_LIMIT   = 500,
  parameter int GAP_TICKS   = 250,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               tick,
  input  logic [RAND_W-1:0]  rand_in,
  input  logic [3:0]         btn,
  output logic [3:0]         prompt,
  output logic               busy,
  output logic               round_win,
  output logic               game_over,
  output logic [SCORE_W-1:0] score
);

  localparam int TIMER_W = 16;
  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
  localparam logic [TIMER_W-1:0] GAP_T      = TIMER_W'(GAP_TICKS);
  localparam logic [TIMER_W-1:0] START_T    = TIMER_W'(START_LIMIT);
  localparam logic [TIMER_W-1:0] STEP_T     = TIMER_W'(LIMIT_STEP);
  localparam logic [TIMER_W-1:0] MIN_T      = TIMER_W'(MIN_LIMIT);
  localparam logic [TIMER_W-1:0] DEC_FLOOR  = TIMER_W'(MIN_LIMIT + LIMIT_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_PROMPT,
    S_RELEASE,
    S_OVER
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   limit_q, limit_d;
  logic [1:0]           last_action_q, last_action_d;
  logic [3:0]           prompt_q, prompt_d;
  logic                 busy_q, busy_d;
  logic                 round_win_q, round_win_d;
  logic                 game_over_q, game_over_d;
  logic [SCORE_W-1:0]   score_q, score_d;

  logic [TIMER_W-1:0]   timer_inc;
  logic [TIMER_W-1:0]   limit_dec;
  logic [1:0]           action_raw;
  logic [1:0]           action;
  logic                 unused_rand;

  // Only the two low random bits select the action.
  assign unused_rand = ^rand_in[RAND_W-1:2];
  assign action_raw  = rand_in[1:0];
  assign action      = (action_raw == last_action_q) ? action_raw + 2'd1 : action_raw;
  assign timer_inc   = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
  // Compare before subtracting so the window never underflows below the floor.
  assign limit_dec   = (limit_q >= DEC_FLOOR) ? limit_q - STEP_T : MIN_T;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    limit_d       = limit_q;
    last_action_d = last_action_q;
    prompt_d      = prompt_q;
    score_d       = score_q;
    round_win_d   = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        prompt_d = 4'b0000;
        if (start) begin
          state_d       = S_GAP;
          score_d       = '0;
          timer_d       = '0;
          limit_d       = START_T;
          last_action_d = 2'd0;
        end
      end
      S_GAP: begin
        prompt_d = 4'b0000;
        if (tick) timer_d = timer_inc;
        if (timer_q >= GAP_T && btn == 4'b0000) begin
          last_action_d = action;
          prompt_d      = 4'b0001 << action;
          timer_d       = '0;
          state_d       = S_PROMPT;
        end
      end
      S_PROMPT: begin
        if (tick) timer_d = timer_inc;
        // A wrong button loses even when the right one is held too.
        if ((btn & ~prompt_q) != 4'b0000) begin
          prompt_d = 4'b0000;
          state_d  = S_OVER;
        end else if (btn == prompt_q) begin
          round_win_d = 1'b1;
          score_d     = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + 1'b1;
          limit_d     = limit_dec;
          prompt_d    = 4'b0000;
          state_d     = S_RELEASE;
        end else if (timer_q >= limit_q) begin
          prompt_d = 4'b0000;
          state_d  = S_OVER;
        end
      end
      S_RELEASE: begin
        prompt_d = 4'b0000;
        if (btn == 4'b0000) begin
          timer_d = '0;
          state_d = S_GAP;
        end
      end
      default: begin
        state_d  = S_IDLE;
        prompt_d = 4'b0000;
      end
    endcase

    busy_d      = (state_d == S_GAP) || (state_d == S_PROMPT) || (state_d == S_RELEASE);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      limit_q       <= START_T;
      last_action_q <= 2'd0;
      prompt_q      <= 4'b0000;
      busy_q        <= 1'b0;
      round_win_q   <= 1'b0;
      game_over_q   <= 1'b0;
      score_q       <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      limit_q       <= limit_d;
      last_action_q <= last_action_d;
      prompt_q      <= prompt_d;
      busy_q        <= busy_d;
      round_win_q   <= round_win_d;
      game_over_q   <= game_over_d;
      score_q       <= score_d;
    end
  end

  assign prompt    = prompt_q;
  assign busy      = busy_q;
  assign round_win = round_win_q;
  assign game_over = game_over_q;
  assign score     = score_q;

endmodule

// File: tb/tb_bopit_round_ctrl.sv
// Bench for the round controller: table of scripted rounds, timing corner cases,
// and a short-gap instance for long win streaks.
`timescale 1ns/1ps
module tb_bopit_round_ctrl;

  typedef struct {
    logic [4:0] rnd;
    logic [3:0] press;
    logic [3:0] exp_prompt;
    logic       exp_win;
    logic       exp_over;
    logic [7:0] exp_score;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start, tick;
  logic [4:0] rand_in;
  logic [3:0] btn;
  logic [3:0] prompt;
  logic       busy, round_win, game_over;
  logic [7:0] score;

  logic       f_start, f_tick;
  logic [4:0] f_rand;
  logic [3:0] f_btn;
  logic [3:0] f_prompt;
  logic       f_busy, f_round_win, f_game_over;
  logic [7:0] f_score;

  int checks = 0;
  int errors = 0;

  vec_t vecs [5];
  vec_t sb_q [$];

  bopit_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .rand_in(rand_in),
    .btn(btn), .prompt(prompt), .busy(busy), .round_win(round_win),
    .game_over(game_over), .score(score)
  );

  bopit_round_ctrl #(.GAP_TICKS(2)) dut_fast (
    .clk(clk), .rst_n(rst_n), .start(f_start), .tick(f_tick), .rand_in(f_rand),
    .btn(f_btn), .prompt(f_prompt), .busy(f_busy), .round_win(f_round_win),
    .game_over(f_game_over), .score(f_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_prompt(output int n);
    n = 0;
    tick = 1'b1;
    while (prompt == 4'b0000 && n < 400) begin
      cyc();
      n++;
    end
    tick = 1'b0;
  endtask

  task automatic f_wait_prompt();
    int n;
    n = 0;
    while (f_prompt == 4'b0000 && n < 50) begin
      cyc();
      n++;
    end
  endtask

  function automatic logic [1:0] next_action(input logic [1:0] r, input logic [1:0] last);
    return (r == last) ? r + 2'd1 : r;
  endfunction

  initial begin
    vec_t v, e;
    int   n;
    logic [1:0] f_last, act;
    int   exp_sc;

    // rnd, press, exp_prompt, win, over, score
    vecs[0] = '{5'b00010, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd1};
    vecs[1] = '{5'b11110, 4'b1000, 4'b1000, 1'b1, 1'b0, 8'd2};
    vecs[2] = '{5'b00001, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'd3};
    vecs[3] = '{5'b10101, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd4};
    vecs[4] = '{5'b01000, 4'b0011, 4'b0001, 1'b0, 1'b1, 8'd4};

    start = 0; tick = 0; rand_in = 0; btn = 0;
    f_start = 0; f_tick = 1; f_rand = 0; f_btn = 0;
    rst_n = 0;
    repeat (3) cyc();
    chk("reset_prompt", prompt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_round_win", round_win, 0);
    chk("reset_game_over", game_over, 0);
    chk("reset_score", score, 0);
    rst_n = 1;
    cyc();
    chk("idle_busy", busy, 0);

    start = 1; cyc(); start = 0;
    chk("start_busy", busy, 1);
    chk("start_game_over", game_over, 0);

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      rand_in = v.rnd;
      wait_prompt(n);
      if (i == 0) chk("gap_exit_latency", n, 251);
      chk($sformatf("v%0d_prompt", i), prompt, v.exp_prompt);
      chk($sformatf("v%0d_busy", i), busy, 1);
      btn = v.press;
      sb_q.push_back(v);
      cyc();
      e = sb_q.pop_front();
      chk($sformatf("v%0d_round_win", i), round_win, e.exp_win);
      chk($sformatf("v%0d_game_over", i), game_over, e.exp_over);
      chk($sformatf("v%0d_score", i), score, e.exp_score);
      chk($sformatf("v%0d_prompt_cleared", i), prompt, 0);
      btn = 0;
      cyc();
      chk($sformatf("v%0d_win_pulse_end", i), round_win, 0);
    end
    chk("over_busy", busy, 0);
    chk("over_held", game_over, 1);

    // Timeout with the full 2000-tick window
    start = 1; cyc(); start = 0;
    chk("restart_score", score, 0);
    chk("restart_game_over", game_over, 0);
    rand_in = 5'b00001;
    wait_prompt(n);
    chk("to_prompt", prompt, 4'b0010);
    tick = 1; repeat (2000) cyc(); tick = 0;
    chk("to_not_yet", game_over, 0);
    cyc();
    chk("to_game_over", game_over, 1);
    chk("to_no_win", round_win, 0);

    // Correct press on the exact timeout cycle wins
    start = 1; cyc(); start = 0;
    rand_in = 5'b00011;
    wait_prompt(n);
    chk("edge_prompt", prompt, 4'b1000);
    tick = 1; repeat (2000) cyc(); tick = 0;
    btn = 4'b1000;
    cyc();
    chk("edge_round_win", round_win, 1);
    chk("edge_game_over", game_over, 0);
    chk("edge_score", score, 1);
    btn = 0; cyc();

    // Window is now 1900 ticks
    rand_in = 5'b00011;
    wait_prompt(n);
    chk("lim1900_prompt", prompt, 4'b0001);
    tick = 1; repeat (1900) cyc(); tick = 0;
    chk("lim1900_not_yet", game_over, 0);
    cyc();
    chk("lim1900_game_over", game_over, 1);

    // Asynchronous reset in the middle of a prompt
    start = 1; cyc(); start = 0;
    rand_in = 5'b00010;
    wait_prompt(n);
    btn = 4'b0100; cyc(); btn = 0; cyc();
    rand_in = 5'b00010;
    wait_prompt(n);
    chk("ar_prompt", prompt, 4'b1000);
    chk("ar_score_before", score, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_prompt_zero", prompt, 0);
    chk("ar_busy_zero", busy, 0);
    chk("ar_score_zero", score, 0);
    chk("ar_game_over_zero", game_over, 0);
    chk("ar_round_win_zero", round_win, 0);
    cyc();
    rst_n = 1;
    cyc();

    // Short-gap instance: 16 wins saturate the window at 500
    f_start = 1; cyc(); f_start = 0;
    f_last = 2'd0;
    for (int r = 0; r < 16; r++) begin
      f_rand = 5'($urandom);
      act = next_action(f_rand[1:0], f_last);
      f_last = act;
      f_wait_prompt();
      chk($sformatf("f16_r%0d_prompt", r), f_prompt, 4'b0001 << act);
      f_btn = 4'b0001 << act;
      cyc();
      chk($sformatf("f16_r%0d_score", r), f_score, r + 1);
      f_btn = 0; cyc();
    end
    f_rand = 5'($urandom);
    act = next_action(f_rand[1:0], f_last);
    f_wait_prompt();
    chk("f_floor_prompt", f_prompt, 4'b0001 << act);
    repeat (500) cyc();
    chk("f_floor_not_yet", f_game_over, 0);
    cyc();
    chk("f_floor_game_over", f_game_over, 1);

    // Long streak: score saturates at 255
    f_start = 1; cyc(); f_start = 0;
    f_last = 2'd0;
    for (int r = 0; r < 257; r++) begin
      f_rand = 5'($urandom);
      act = next_action(f_rand[1:0], f_last);
      f_last = act;
      f_wait_prompt();
      chk($sformatf("fsat_r%0d_prompt", r), f_prompt, 4'b0001 << act);
      f_btn = 4'b0001 << act;
      cyc();
      exp_sc = (r + 1 > 255) ? 255 : r + 1;
      chk($sformatf("fsat_r%0d_score", r), f_score, exp_sc);
      f_btn = 0; cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
